// File: rtl/lru_tag_store_4way_if.sv
// Request, response and LRU-tracker signals of the 4-way tag store, as seen
// from the store (slave) and from the controller/tracker side (master).
interface lru_tag_store_4way_if #(
  parameter int TAG_W  = 8,
  parameter int DATA_W = 16
);
  logic              req_valid_i;
  logic              req_ready_o;
  logic [1:0]        req_op_i;
  logic [TAG_W-1:0]  req_tag_i;
  logic [DATA_W-1:0] req_data_i;

  logic              resp_valid_o;
  logic              resp_ready_i;
  logic              resp_hit_o;
  logic [1:0]        resp_way_o;
  logic [DATA_W-1:0] resp_data_o;

  logic              lru_access_o;
  logic              lru_update_o;
  logic [1:0]        lru_index_o;
  logic [1:0]        lru_victim_i;

  modport slave (
    input  req_valid_i, req_op_i, req_tag_i, req_data_i, resp_ready_i, lru_victim_i,
    output req_ready_o, resp_valid_o, resp_hit_o, resp_way_o, resp_data_o,
           lru_access_o, lru_update_o, lru_index_o
  );

  modport master (
    output req_valid_i, req_op_i, req_tag_i, req_data_i, resp_ready_i, lru_victim_i,
    input  req_ready_o, resp_valid_o, resp_hit_o, resp_way_o, resp_data_o,
           lru_access_o, lru_update_o, lru_index_o
  );
endinterface

// File: rtl/lru_tag_store_4way.sv
// Four-entry fully associative tag/data store. Each request walks
// IDLE -> EXEC -> RESP; the table, response and LRU pulse registers are all
// updated together at the end of EXEC.
module lru_tag_store_4way #(
  parameter int TAG_W  = 8,
  parameter int DATA_W = 16
) (
  input logic                  clk,
  input logic                  rst,
  lru_tag_store_4way_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [1:0] OP_LOOKUP = 2'b00;
  localparam logic [1:0] OP_WRITE  = 2'b01;
  localparam logic [1:0] OP_INVAL  = 2'b10;

  state_t state_reg, state_next;

  // latched request
  logic [1:0]        op_reg;
  logic [TAG_W-1:0]  tag_reg;
  logic [DATA_W-1:0] wdata_reg;

  // table: only the valid bits carry reset
  logic [3:0]        valid_reg;
  logic [TAG_W-1:0]  tag_mem  [4];
  logic [DATA_W-1:0] data_mem [4];

  // lookup results
  logic [3:0] hit_vec;
  logic       hit_any;
  logic [1:0] hit_way;
  logic       inv_any;
  logic [1:0] inv_way;
  logic [1:0] target_way;

  // response and LRU pulse registers
  logic              resp_hit_reg, resp_hit_next;
  logic [1:0]        resp_way_reg, resp_way_next;
  logic [DATA_W-1:0] resp_data_reg, resp_data_next;
  logic              access_reg, access_next;
  logic              update_reg, update_next;
  logic [1:0]        index_reg, index_next;

  logic accept;
  logic write_en;
  logic inval_en;

  assign accept = (state_reg == IDLE) && bus.req_valid_i;

  // Parallel tag compare; an invalid way never matches.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_cmp
      assign hit_vec[gi] = valid_reg[gi] && (tag_mem[gi] == tag_reg);
    end
  endgenerate

  // Lowest-index hit and lowest-index free way, then the write target.
  always_comb begin
    hit_any = |hit_vec;
    inv_any = ~&valid_reg;
    hit_way = 2'd0;
    inv_way = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (hit_vec[i])    hit_way = 2'(i);
      if (!valid_reg[i]) inv_way = 2'(i);
    end
    if (hit_any)      target_way = hit_way;
    else if (inv_any) target_way = inv_way;
    else              target_way = bus.lru_victim_i;
  end

  // Next-state, response and LRU pulse decisions.
  always_comb begin
    state_next     = state_reg;
    resp_hit_next  = resp_hit_reg;
    resp_way_next  = resp_way_reg;
    resp_data_next = resp_data_reg;
    access_next    = 1'b0;
    update_next    = 1'b0;
    index_next     = index_reg;
    write_en       = 1'b0;
    inval_en       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.req_valid_i) state_next = EXEC;
      end
      EXEC: begin
        state_next     = RESP;
        resp_hit_next  = 1'b0;
        resp_way_next  = 2'd0;
        resp_data_next = '0;
        case (op_reg)
          OP_LOOKUP: begin
            if (hit_any) begin
              resp_hit_next  = 1'b1;
              resp_way_next  = hit_way;
              resp_data_next = data_mem[hit_way];
              access_next    = 1'b1;
              index_next     = hit_way;
            end
          end
          OP_WRITE: begin
            resp_hit_next = hit_any;
            resp_way_next = target_way;
            access_next   = 1'b1;
            index_next    = target_way;
            write_en      = 1'b1;
          end
          OP_INVAL: begin
            if (hit_any) begin
              resp_hit_next = 1'b1;
              resp_way_next = hit_way;
              update_next   = 1'b1;
              index_next    = hit_way;
              inval_en      = 1'b1;
            end
          end
          default: ;
        endcase
      end
      RESP: begin
        if (bus.resp_ready_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State, response and LRU pulse registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= IDLE;
      resp_hit_reg  <= 1'b0;
      resp_way_reg  <= 2'd0;
      resp_data_reg <= '0;
      access_reg    <= 1'b0;
      update_reg    <= 1'b0;
      index_reg     <= 2'd0;
    end else begin
      state_reg     <= state_next;
      resp_hit_reg  <= resp_hit_next;
      resp_way_reg  <= resp_way_next;
      resp_data_reg <= resp_data_next;
      access_reg    <= access_next;
      update_reg    <= update_next;
      index_reg     <= index_next;
    end
  end

  // Capture the accepted request for use in EXEC.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_reg    <= bus.req_op_i;
      tag_reg   <= bus.req_tag_i;
      wdata_reg <= bus.req_data_i;
    end
  end

  // Valid bits: set on write commit, cleared on invalidate hit or reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_reg <= 4'b0000;
    end else if (write_en) begin
      valid_reg[target_way] <= 1'b1;
    end else if (inval_en) begin
      valid_reg[hit_way] <= 1'b0;
    end
  end

  // Tag/data storage per way; a write abandoned by reset is not committed.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_way
      always_ff @(posedge clk) begin
        if (rst && write_en && (target_way == 2'(gi))) begin
          tag_mem[gi]  <= tag_reg;
          data_mem[gi] <= wdata_reg;
        end
      end
    end
  endgenerate

  assign bus.req_ready_o  = (state_reg == IDLE) && rst;
  assign bus.resp_valid_o = (state_reg == RESP);
  assign bus.resp_hit_o   = resp_hit_reg;
  assign bus.resp_way_o   = resp_way_reg;
  assign bus.resp_data_o  = resp_data_reg;
  assign bus.lru_access_o = access_reg;
  assign bus.lru_update_o = update_reg;
  assign bus.lru_index_o  = index_reg;

endmodule

// File: tb/tb_lru_tag_store_4way.sv
// Testbench for lru_tag_store_4way: directed scenarios, reset cases and a
// randomized run checked against a small array model of the table.
module tb_lru_tag_store_4way;
  localparam int TAG_W  = 8;
  localparam int DATA_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  lru_tag_store_4way_if #(.TAG_W(TAG_W), .DATA_W(DATA_W)) bus ();

  lru_tag_store_4way #(.TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // reference table
  bit                m_valid [4];
  logic [TAG_W-1:0]  m_tag   [4];
  logic [DATA_W-1:0] m_data  [4];

  // directed stimulus table: op, tag, data, victim, response hold cycles
  localparam int ND = 15;
  int d_op   [ND] = '{0, 1, 1, 1, 1, 1, 0, 0, 1, 0, 2, 1, 0, 3, 0};
  int d_tag  [ND] = '{'h12, 'h10, 'h11, 'h12, 'h13, 'h20, 'h20, 'h12,
                      'h11, 'h11, 'h10, 'h30, 'h30, 'h30, 'h10};
  int d_data [ND] = '{0, 'hA000, 'hA001, 'hA002, 'hA003, 'hBEEF, 0, 0,
                      'h5555, 0, 0, 'h1234, 0, 0, 0};
  int d_vic  [ND] = '{0, 0, 0, 0, 0, 2, 0, 0, 3, 0, 0, 3, 0, 0, 0};
  int d_hold [ND] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4, 0, 0};

  function automatic void model_clear();
    for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
  endfunction

  // Expected response packed as {hit, way, data, access, update, index}.
  function automatic void model_apply(input logic [1:0] op, input logic [TAG_W-1:0] tag,
                                      input logic [DATA_W-1:0] data, input logic [1:0] victim,
                                      output logic [22:0] exp, output int exp_pulses);
    int h;
    int inv;
    int tgt;
    h   = -1;
    inv = -1;
    for (int i = 0; i < 4; i++) if (m_valid[i] && m_tag[i] == tag) h = i;
    for (int i = 3; i >= 0; i--) if (!m_valid[i]) inv = i;
    exp        = '0;
    exp_pulses = 0;
    case (op)
      2'd0: if (h >= 0) begin
        exp = {1'b1, 2'(h), m_data[h], 1'b1, 1'b0, 2'(h)};
        exp_pulses = 1;
      end
      2'd1: begin
        tgt = (h >= 0) ? h : ((inv >= 0) ? inv : int'(victim));
        exp = {(h >= 0), 2'(tgt), 16'h0000, 1'b1, 1'b0, 2'(tgt)};
        exp_pulses = 1;
        m_valid[tgt] = 1'b1;
        m_tag[tgt]   = tag;
        m_data[tgt]  = data;
      end
      2'd2: if (h >= 0) begin
        exp = {1'b1, 2'(h), 16'h0000, 1'b0, 1'b1, 2'(h)};
        exp_pulses = 1;
        m_valid[h] = 1'b0;
      end
      default: ;
    endcase
  endfunction

  task automatic sample_lru(inout int pulses, inout logic [1:0] pidx, inout logic acc_s,
                            inout logic upd_s, inout bit ok);
    if (bus.lru_access_o === 1'b1 && bus.lru_update_o === 1'b1) ok = 1'b0;
    if (bus.lru_access_o !== 1'b0 || bus.lru_update_o !== 1'b0) begin
      pulses++;
      pidx  = bus.lru_index_o;
      acc_s = bus.lru_access_o;
      upd_s = bus.lru_update_o;
    end
  endtask

  // Drives one request from a negedge and returns at the negedge after the
  // response is consumed. proto_ok drops on any handshake/stability problem.
  task automatic run_req(input logic [1:0] op, input logic [TAG_W-1:0] tag,
                         input logic [DATA_W-1:0] data, input logic [1:0] victim, input int hold,
                         output logic [22:0] obs, output int pulses, output bit proto_ok);
    int n;
    logic acc_s;
    logic upd_s;
    logic [1:0] pidx;
    logic rhit;
    logic [1:0] rway;
    logic [DATA_W-1:0] rdata;
    proto_ok = 1'b1;
    pulses   = 0;
    acc_s    = 1'b0;
    upd_s    = 1'b0;
    pidx     = 2'd0;
    bus.req_valid_i  = 1'b1;
    bus.req_op_i     = op;
    bus.req_tag_i    = tag;
    bus.req_data_i   = data;
    bus.lru_victim_i = victim;
    bus.resp_ready_i = 1'b0;
    n = 0;
    while (bus.req_ready_o !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (n >= 10) proto_ok = 1'b0;
    @(negedge clk);  // EXEC
    bus.req_valid_i = 1'b0;
    bus.req_op_i    = 2'($urandom);
    bus.req_tag_i   = 8'($urandom);
    if (bus.req_ready_o !== 1'b0 || bus.resp_valid_o !== 1'b0) proto_ok = 1'b0;
    sample_lru(pulses, pidx, acc_s, upd_s, proto_ok);
    @(negedge clk);  // first RESP cycle
    bus.lru_victim_i = 2'($urandom);
    if (bus.req_ready_o !== 1'b0 || bus.resp_valid_o !== 1'b1) proto_ok = 1'b0;
    rhit  = bus.resp_hit_o;
    rway  = bus.resp_way_o;
    rdata = bus.resp_data_o;
    sample_lru(pulses, pidx, acc_s, upd_s, proto_ok);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (bus.req_ready_o !== 1'b0 || bus.resp_valid_o !== 1'b1) proto_ok = 1'b0;
      if (bus.resp_hit_o !== rhit || bus.resp_way_o !== rway || bus.resp_data_o !== rdata)
        proto_ok = 1'b0;
      sample_lru(pulses, pidx, acc_s, upd_s, proto_ok);
    end
    bus.resp_ready_i = 1'b1;
    @(negedge clk);
    bus.resp_ready_i = 1'b0;
    if (bus.resp_valid_o !== 1'b0 || bus.req_ready_o !== 1'b1) proto_ok = 1'b0;
    sample_lru(pulses, pidx, acc_s, upd_s, proto_ok);
    obs = {rhit, rway, rdata, acc_s, upd_s, pidx};
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.req_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready: got %b expected 0", bus.req_ready_o);
    end
    checks++;
    if ({bus.resp_valid_o, bus.resp_hit_o, bus.resp_way_o, bus.resp_data_o,
         bus.lru_access_o, bus.lru_update_o, bus.lru_index_o} !== 24'h0) begin
      failures++;
      $display("FAIL reset_outputs: got valid=%b hit=%b way=%h data=%h acc=%b upd=%b idx=%h expected all 0",
               bus.resp_valid_o, bus.resp_hit_o, bus.resp_way_o, bus.resp_data_o,
               bus.lru_access_o, bus.lru_update_o, bus.lru_index_o);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.req_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_ready: got %b expected 1", bus.req_ready_o);
    end
    model_clear();
    $display("txn reset done");
  endtask

  task automatic test_directed();
    logic [22:0] obs;
    logic [22:0] exp;
    int pulses;
    int exp_pulses;
    bit ok;
    for (int i = 0; i < ND; i++) begin
      run_req(2'(d_op[i]), 8'(d_tag[i]), 16'(d_data[i]), 2'(d_vic[i]), d_hold[i], obs, pulses, ok);
      model_apply(2'(d_op[i]), 8'(d_tag[i]), 16'(d_data[i]), 2'(d_vic[i]), exp, exp_pulses);
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL directed_%0d_resp: got hit=%b way=%0d data=%h acc=%b upd=%b idx=%0d expected hit=%b way=%0d data=%h acc=%b upd=%b idx=%0d",
                 i, obs[22], obs[21:20], obs[19:4], obs[3], obs[2], obs[1:0],
                 exp[22], exp[21:20], exp[19:4], exp[3], exp[2], exp[1:0]);
      end
      checks++;
      if (pulses != exp_pulses) begin
        failures++;
        $display("FAIL directed_%0d_pulses: got %0d expected %0d", i, pulses, exp_pulses);
      end
      checks++;
      if (ok !== 1'b1) begin
        failures++;
        $display("FAIL directed_%0d_handshake: got %b expected 1", i, ok);
      end
      $display("txn directed %0d op=%0d tag=%h hit=%b way=%0d data=%h pulses=%0d",
               i, d_op[i], d_tag[i], obs[22], obs[21:20], obs[19:4], pulses);
    end
  endtask

  task automatic test_reset_mid_write();
    logic [22:0] obs;
    logic [22:0] exp;
    int pulses;
    int exp_pulses;
    bit ok;
    int tags [3] = '{'h50, 'h30, 'h51};
    run_req(2'd1, 8'h50, 16'h7777, 2'd0, 0, obs, pulses, ok);
    model_apply(2'd1, 8'h50, 16'h7777, 2'd0, exp, exp_pulses);
    checks++;
    if (obs !== exp || ok !== 1'b1) begin
      failures++;
      $display("FAIL midrst_prewrite: got %h ok=%b expected %h ok=1", obs, ok, exp);
    end
    // start a write and pull reset while it sits in EXEC
    bus.req_valid_i  = 1'b1;
    bus.req_op_i     = 2'd1;
    bus.req_tag_i    = 8'h51;
    bus.req_data_i   = 16'h9999;
    bus.lru_victim_i = 2'd0;
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.resp_valid_o, bus.lru_access_o, bus.lru_update_o, bus.req_ready_o} !== 4'b0000) begin
      failures++;
      $display("FAIL midrst_during: got valid=%b acc=%b upd=%b ready=%b expected all 0",
               bus.resp_valid_o, bus.lru_access_o, bus.lru_update_o, bus.req_ready_o);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.resp_valid_o, bus.lru_access_o, bus.lru_update_o, bus.req_ready_o} !== 4'b0001) begin
      failures++;
      $display("FAIL midrst_after: got valid=%b acc=%b upd=%b ready=%b expected 0 0 0 1",
               bus.resp_valid_o, bus.lru_access_o, bus.lru_update_o, bus.req_ready_o);
    end
    model_clear();
    $display("txn reset during write exec");
    for (int i = 0; i < 3; i++) begin
      run_req(2'd0, 8'(tags[i]), 16'h0, 2'd0, 0, obs, pulses, ok);
      model_apply(2'd0, 8'(tags[i]), 16'h0, 2'd0, exp, exp_pulses);
      checks++;
      if (obs !== exp || pulses != exp_pulses || ok !== 1'b1) begin
        failures++;
        $display("FAIL midrst_lookup_%h: got %h pulses=%0d ok=%b expected %h pulses=%0d ok=1",
                 tags[i], obs, pulses, ok, exp, exp_pulses);
      end
      $display("txn post-reset lookup tag=%h hit=%b", tags[i], obs[22]);
    end
  endtask

  task automatic test_random();
    logic [22:0] obs;
    logic [22:0] exp;
    int pulses;
    int exp_pulses;
    bit ok;
    logic [1:0] op;
    logic [TAG_W-1:0] tag;
    logic [DATA_W-1:0] data;
    logic [1:0] vic;
    int hold;
    for (int i = 0; i < 150; i++) begin
      op   = 2'($urandom_range(0, 3));
      tag  = 8'(8'h40 + $urandom_range(0, 5));
      data = 16'($urandom);
      vic  = 2'($urandom_range(0, 3));
      hold = $urandom_range(0, 2);
      run_req(op, tag, data, vic, hold, obs, pulses, ok);
      model_apply(op, tag, data, vic, exp, exp_pulses);
      checks++;
      if (obs !== exp || pulses != exp_pulses || ok !== 1'b1) begin
        failures++;
        $display("FAIL random_%0d: op=%0d tag=%h got hit=%b way=%0d data=%h acc=%b upd=%b idx=%0d pulses=%0d ok=%b expected hit=%b way=%0d data=%h acc=%b upd=%b idx=%0d pulses=%0d ok=1",
                 i, op, tag, obs[22], obs[21:20], obs[19:4], obs[3], obs[2], obs[1:0], pulses, ok,
                 exp[22], exp[21:20], exp[19:4], exp[3], exp[2], exp[1:0], exp_pulses);
      end
      $display("txn random %0d op=%0d tag=%h vic=%0d hit=%b way=%0d data=%h",
               i, op, tag, vic, obs[22], obs[21:20], obs[19:4]);
    end
  endtask

  initial begin
    bus.req_valid_i  = 1'b0;
    bus.req_op_i     = 2'd3;
    bus.req_tag_i    = '0;
    bus.req_data_i   = '0;
    bus.resp_ready_i = 1'b0;
    bus.lru_victim_i = 2'd0;
    test_reset();
    test_directed();
    test_reset_mid_write();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
